// File: rtl/matrix_result_drain_if.sv
// Tile input bus from the calc array and result stream to the downstream writer.
interface matrix_result_drain_if #(
  parameter int unsigned DATA_WIDTH             = 8,
  parameter int unsigned FIRST_MATRIX_ROW_SIZE  = 3,
  parameter int unsigned SECOND_MATRIX_COL_SIZE = 3,
  parameter int unsigned FIRST_BLOCK_ROW_SIZE   = 3,
  parameter int unsigned SECOND_BLOCK_COL_SIZE  = 3
);
  localparam int unsigned RES_WIDTH = 2 * DATA_WIDTH;
  localparam int unsigned TILES_R   = (FIRST_MATRIX_ROW_SIZE + FIRST_BLOCK_ROW_SIZE - 1) / FIRST_BLOCK_ROW_SIZE;
  localparam int unsigned TILES_C   = (SECOND_MATRIX_COL_SIZE + SECOND_BLOCK_COL_SIZE - 1) / SECOND_BLOCK_COL_SIZE;
  localparam int unsigned TR_W      = (TILES_R > 1) ? $clog2(TILES_R) : 1;
  localparam int unsigned TC_W      = (TILES_C > 1) ? $clog2(TILES_C) : 1;
  localparam int unsigned ROW_W     = (FIRST_MATRIX_ROW_SIZE > 1) ? $clog2(FIRST_MATRIX_ROW_SIZE) : 1;
  localparam int unsigned COL_W     = (SECOND_MATRIX_COL_SIZE > 1) ? $clog2(SECOND_MATRIX_COL_SIZE) : 1;
  localparam int unsigned TDATA_W   = FIRST_BLOCK_ROW_SIZE * SECOND_BLOCK_COL_SIZE * RES_WIDTH;

  // tile side
  logic                 tile_valid;
  logic                 tile_ready;
  logic [TR_W-1:0]      tile_row_idx;
  logic [TC_W-1:0]      tile_col_idx;
  logic                 tile_first;
  logic                 tile_last;
  logic [TDATA_W-1:0]   tile_data;

  // result side
  logic                 out_valid;
  logic                 out_ready;
  logic [RES_WIDTH-1:0] out_data;
  logic [ROW_W-1:0]     out_row;
  logic [COL_W-1:0]     out_col;
  logic                 out_last;
  logic                 busy;

  modport master (
    output tile_valid, tile_row_idx, tile_col_idx, tile_first, tile_last, tile_data, out_ready,
    input  tile_ready, out_valid, out_data, out_row, out_col, out_last, busy
  );

  modport slave (
    input  tile_valid, tile_row_idx, tile_col_idx, tile_first, tile_last, tile_data, out_ready,
    output tile_ready, out_valid, out_data, out_row, out_col, out_last, busy
  );
endinterface

// File: rtl/matrix_result_drain.sv
// Collects k-block partial tiles into a result buffer, then streams the
// finished matrix out row-major once every tile has seen its last k-block.
module matrix_result_drain #(
  parameter int unsigned DATA_WIDTH             = 8,
  parameter int unsigned FIRST_MATRIX_ROW_SIZE  = 3,
  parameter int unsigned SECOND_MATRIX_COL_SIZE = 3,
  parameter int unsigned FIRST_BLOCK_ROW_SIZE   = 3,
  parameter int unsigned SECOND_BLOCK_COL_SIZE  = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  matrix_result_drain_if.slave  bus
);
  localparam int unsigned M         = FIRST_MATRIX_ROW_SIZE;
  localparam int unsigned N         = SECOND_MATRIX_COL_SIZE;
  localparam int unsigned BR        = FIRST_BLOCK_ROW_SIZE;
  localparam int unsigned BC        = SECOND_BLOCK_COL_SIZE;
  localparam int unsigned RES_WIDTH = 2 * DATA_WIDTH;
  localparam int unsigned TILES_R   = (M + BR - 1) / BR;
  localparam int unsigned TILES_C   = (N + BC - 1) / BC;
  localparam int unsigned NT        = TILES_R * TILES_C;
  localparam int unsigned NE        = M * N;
  localparam int unsigned TR_W      = (TILES_R > 1) ? $clog2(TILES_R) : 1;
  localparam int unsigned TC_W      = (TILES_C > 1) ? $clog2(TILES_C) : 1;
  localparam int unsigned ROW_W     = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned COL_W     = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned IDX_W     = (NE > 1) ? $clog2(NE) : 1;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [RES_WIDTH-1:0] r_buf     [NE];
  logic [RES_WIDTH-1:0] w_buf_nxt [NE];
  logic [RES_WIDTH-1:0] w_elem    [NE];
  logic [NE-1:0]        w_hit;

  logic [NT-1:0]        r_done;
  logic [NT-1:0]        w_done_nxt;
  logic [NT-1:0]        w_done_upd;
  logic [NT-1:0]        w_tile_hit;

  logic                 w_accept;
  logic                 w_all_done;
  logic                 w_handshake;

  logic                 r_tile_ready;
  logic                 r_out_valid;
  logic [RES_WIDTH-1:0] r_out_data;
  logic [ROW_W-1:0]     r_out_row;
  logic [COL_W-1:0]     r_out_col;
  logic                 r_out_last;
  logic                 r_busy;

  logic                 w_tile_ready_nxt;
  logic                 w_out_valid_nxt;
  logic [RES_WIDTH-1:0] w_out_data_nxt;
  logic [ROW_W-1:0]     w_out_row_nxt;
  logic [COL_W-1:0]     w_out_col_nxt;
  logic                 w_out_last_nxt;
  logic                 w_busy_nxt;

  logic [ROW_W-1:0]     w_adv_row;
  logic [COL_W-1:0]     w_adv_col;
  logic [IDX_W-1:0]     w_adv_idx;
  logic                 w_adv_last;

  assign w_accept    = bus.tile_valid && r_tile_ready;
  assign w_handshake = r_out_valid && bus.out_ready;

  // Per-element buffer update: only positions inside the matrix are ever
  // hit, so edge padding and out-of-range tile indices fall away naturally.
  for (genvar r = 0; r < int'(M); r++) begin : g_row
    for (genvar c = 0; c < int'(N); c++) begin : g_col
      localparam int unsigned K = r * N + c;
      localparam int unsigned E = (r % BR) * BC + (c % BC);
      assign w_hit[K]     = w_accept
                         && (bus.tile_row_idx == TR_W'(r / BR))
                         && (bus.tile_col_idx == TC_W'(c / BC));
      assign w_elem[K]    = bus.tile_data[E*RES_WIDTH +: RES_WIDTH];
      assign w_buf_nxt[K] = !w_hit[K]      ? r_buf[K]
                          : bus.tile_first ? w_elem[K]
                          :                  r_buf[K] + w_elem[K];
    end
  end

  // Done-flag set for the addressed tile; setting an already-set flag is harmless.
  for (genvar tr = 0; tr < int'(TILES_R); tr++) begin : g_trow
    for (genvar tc = 0; tc < int'(TILES_C); tc++) begin : g_tcol
      assign w_tile_hit[tr*TILES_C + tc] = w_accept && bus.tile_last
                                        && (bus.tile_row_idx == TR_W'(tr))
                                        && (bus.tile_col_idx == TC_W'(tc));
    end
  end

  assign w_done_upd = r_done | w_tile_hit;
  assign w_all_done = &w_done_upd;

  // Row-major successor of the element currently presented.
  always_comb begin
    w_adv_row = r_out_row;
    w_adv_col = r_out_col + 1'b1;
    if (r_out_col == COL_W'(N - 1)) begin
      w_adv_col = '0;
      w_adv_row = r_out_row + 1'b1;
    end
  end

  assign w_adv_idx  = IDX_W'(w_adv_row) * IDX_W'(N) + IDX_W'(w_adv_col);
  assign w_adv_last = (w_adv_row == ROW_W'(M - 1)) && (w_adv_col == COL_W'(N - 1));

  // Result buffer: no reset, every drain is preceded by tile_first overwrites.
  always_ff @(posedge clock) begin
    for (int k = 0; k < int'(NE); k++) begin
      r_buf[k] <= w_buf_nxt[k];
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_done_nxt       = r_done;
    w_tile_ready_nxt = r_tile_ready;
    w_out_valid_nxt  = r_out_valid;
    w_out_data_nxt   = r_out_data;
    w_out_row_nxt    = r_out_row;
    w_out_col_nxt    = r_out_col;
    w_out_last_nxt   = r_out_last;
    w_busy_nxt       = r_busy;
    case (r_state)
      COLLECT: begin
        w_done_nxt = w_done_upd;
        if (w_accept && w_all_done) begin
          // first element must already include the completing tile
          w_state_nxt      = DRAIN;
          w_tile_ready_nxt = 1'b0;
          w_out_valid_nxt  = 1'b1;
          w_busy_nxt       = 1'b1;
          w_out_data_nxt   = w_buf_nxt[0];
          w_out_row_nxt    = '0;
          w_out_col_nxt    = '0;
          w_out_last_nxt   = (NE == 1);
        end
      end
      DRAIN: begin
        if (w_handshake) begin
          if (r_out_last) begin
            w_state_nxt      = COLLECT;
            w_done_nxt       = '0;
            w_tile_ready_nxt = 1'b1;
            w_out_valid_nxt  = 1'b0;
            w_busy_nxt       = 1'b0;
            w_out_last_nxt   = 1'b0;
            w_out_row_nxt    = '0;
            w_out_col_nxt    = '0;
          end else begin
            w_out_row_nxt    = w_adv_row;
            w_out_col_nxt    = w_adv_col;
            w_out_data_nxt   = r_buf[w_adv_idx];
            w_out_last_nxt   = w_adv_last;
          end
        end
      end
      default: begin
        w_state_nxt = COLLECT;
      end
    endcase
  end

  // Registered outputs and tile completion flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_done       <= '0;
      r_tile_ready <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_row    <= '0;
      r_out_col    <= '0;
      r_out_last   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_done       <= w_done_nxt;
      r_tile_ready <= w_tile_ready_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_data   <= w_out_data_nxt;
      r_out_row    <= w_out_row_nxt;
      r_out_col    <= w_out_col_nxt;
      r_out_last   <= w_out_last_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign bus.tile_ready = r_tile_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_row    = r_out_row;
  assign bus.out_col    = r_out_col;
  assign bus.out_last   = r_out_last;
  assign bus.busy       = r_busy;

endmodule
